// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared definitions for the loadable instruction memory:
//               controller state encoding, the built-in default program
//               image and the even-parity helper used when parity storage
//               is compiled in (macro IMEM_PARITY_EN).
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    // Controller states
    localparam logic [1:0] c_ST_INIT = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_LOAD = 2'd2;

    // Built-in default program occupying addresses 0..4; every other
    // address initialises to zero.
    localparam int unsigned c_IMG_WORDS = 5;
    localparam logic [7:0]  c_IMG_0     = 8'h44;
    localparam logic [7:0]  c_IMG_1     = 8'h49;
    localparam logic [7:0]  c_IMG_2     = 8'h18;
    localparam logic [7:0]  c_IMG_3     = 8'h89;
    localparam logic [7:0]  c_IMG_4     = 8'hC3;

    function automatic logic [7:0] default_word(input int unsigned idx);
        logic [7:0] word;
        case (idx)
            0:       word = c_IMG_0;
            1:       word = c_IMG_1;
            2:       word = c_IMG_2;
            3:       word = c_IMG_3;
            4:       word = c_IMG_4;
            default: word = 8'h00;
        endcase
        return word;
    endfunction

    // Even parity: the returned bit makes the total number of ones even.
    // Words are zero-extended to 64 bits, which does not alter parity, so
    // this serves any DATA_W up to 64.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
// Module      : imem_ram
// Description : Single-port synchronous RAM, DEPTH x WIDTH, with write
//               enable and a registered read port. The read register only
//               updates on i_re, so its value is held between reads.
//   clk     in   clock
//   rst     in   synchronous active-high reset (clears read register only)
//   i_we    in   write enable
//   i_re    in   read enable
//   i_addr  in   shared read/write address
//   i_wdata in   write data
//   o_rdata out  registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module imem_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Storage array has no reset; contents are rebuilt by the INIT sweep.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/imem_loadable.sv
`default_nettype none
// ============================================================================
// Module      : imem_loadable
// Description : Writable instruction memory. After reset it copies the
//               default program into RAM (INIT, one word per cycle), then
//               serves 1-cycle-latency fetches (RUN). A valid/ready load
//               port (LOAD) replaces words starting at ld_base, wrapping at
//               DEPTH. Optional macro IMEM_PARITY_EN adds one even-parity
//               bit per word, checked on fetch and reported on par_err.
//   clk, reset              clock, synchronous active-high reset
//   rd_en, rd_addr          fetch request / address
//   instr, instr_valid      fetched word / one-cycle fresh-result pulse
//   rd_err                  fetch address was >= DEPTH
//   busy                    INIT or LOAD in progress, fetches dropped
//   ld_start, ld_base       begin a load at ld_base (RUN only)
//   ld_valid, ld_data       load word handshake
//   ld_last, ld_ready       final word marker / load port ready
//   par_err                 stored parity mismatch on the fetched word
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loadable
    import imem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              rd_err,
    output logic              busy,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              par_err
);

    localparam int c_IDX_W = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
    localparam int c_RAM_W = DATA_W + 1;
`else
    localparam int c_RAM_W = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] c_LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_ONE     = ADDR_W'(1);
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   c_DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [ADDR_W-1:0]  r_ptr;
    logic [ADDR_W-1:0]  w_ptr_nxt;
    logic               r_instr_valid;
    logic               r_rd_err;

    logic               w_rd_in_range;
    logic               w_base_in_range;
    logic               w_fetch;
    logic               w_ld_accept;
    logic               w_we;
    logic               w_re;
    logic [c_IDX_W-1:0] w_addr;
    logic [DATA_W-1:0]  w_wdata_raw;
    logic [c_RAM_W-1:0] w_wdata;
    logic [c_RAM_W-1:0] w_rdata;

    assign w_rd_in_range   = ({1'b0, rd_addr} < c_DEPTH_X);
    assign w_base_in_range = ({1'b0, ld_base} < c_DEPTH_X);

    // A load request in the same cycle takes priority over a fetch.
    assign w_fetch     = (r_state == c_ST_RUN) && rd_en && !ld_start;
    assign w_ld_accept = (r_state == c_ST_LOAD) && ld_valid;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            c_ST_INIT: begin
                if (r_ptr == c_LAST) begin
                    w_state_nxt = c_ST_RUN;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt = r_ptr + c_ONE;
                end
            end
            c_ST_RUN: begin
                if (ld_start) begin
                    w_state_nxt = c_ST_LOAD;
                    w_ptr_nxt   = w_base_in_range ? ld_base : '0;
                end
            end
            c_ST_LOAD: begin
                if (ld_valid) begin
                    w_ptr_nxt = (r_ptr == c_LAST) ? '0 : (r_ptr + c_ONE);
                    if (ld_last) begin
                        w_state_nxt = c_ST_RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_INIT;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RAM port: writes come from the pointer (INIT sweep or load), reads
    // from the fetch address. Writes never occur in RUN, so the single
    // port is never contended.
    // ------------------------------------------------------------------
    assign w_we   = (r_state == c_ST_INIT) || w_ld_accept;
    assign w_re   = w_fetch && w_rd_in_range;
    assign w_addr = w_we ? r_ptr[c_IDX_W-1:0] : rd_addr[c_IDX_W-1:0];

    assign w_wdata_raw = (r_state == c_ST_INIT)
                       ? DATA_W'(default_word(32'(r_ptr)))
                       : ld_data;

`ifdef IMEM_PARITY_EN
    assign w_wdata = {even_parity(64'(w_wdata_raw)), w_wdata_raw};
`else
    assign w_wdata = w_wdata_raw;
`endif

    imem_ram #(
        .WIDTH (c_RAM_W),
        .DEPTH (DEPTH),
        .IDX_W (c_IDX_W)
    ) u_ram (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // ------------------------------------------------------------------
    // Fetch status; rd_err is held alongside the data until the next
    // accepted fetch, and masks the (stale) RAM output to zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_valid <= 1'b0;
            r_rd_err      <= 1'b0;
        end else begin
            r_instr_valid <= w_fetch;
            if (w_fetch) begin
                r_rd_err <= !w_rd_in_range;
            end
        end
    end

    assign instr       = r_rd_err ? '0 : w_rdata[DATA_W-1:0];
    assign instr_valid = r_instr_valid;
    assign rd_err      = r_rd_err;
    assign busy        = (r_state != c_ST_RUN);
    assign ld_ready    = (r_state == c_ST_LOAD);

`ifdef IMEM_PARITY_EN
    assign par_err = r_instr_valid && !r_rd_err &&
                     (even_parity(64'(w_rdata[DATA_W-1:0])) != w_rdata[DATA_W]);
`else
    assign par_err = 1'b0;
`endif

endmodule
`default_nettype wire
